// File: rtl/pc8001m_audio_mix.sv
// rtl/pc8001m_audio_mix.sv - multi-channel volume-weighted audio mixer with saturating output
module pc8001m_audio_mix #(
  parameter int NCH   = 4,
  parameter int IW    = 4,
  parameter int VW    = 4,
  parameter int OW    = 16,
  parameter int SHIFT = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              sample_ce,
  input  logic [NCH*IW-1:0] ch_in,
  input  logic [NCH*VW-1:0] ch_vol,
  input  logic [NCH-1:0]    ch_mute,
  input  logic              master_mute,
  output logic [OW-1:0]     audio_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = IW + VW;
  localparam int AW = PW + CW;
  // Saturation width holds the full shifted sum plus one spare bit, so the compare never truncates.
  localparam int SW = (((AW + SHIFT) > OW) ? (AW + SHIFT) : OW) + 1;
  localparam logic [SW-1:0] OMAX = {{(SW-OW){1'b0}}, {OW{1'b1}}};
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        rst_sync;
  logic              rst_n_i;

  logic [NCH*IW-1:0] sh_in;
  logic [NCH*VW-1:0] sh_vol;
  logic [NCH-1:0]    sh_mute;
  logic              sh_master;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     idx;

  logic              capture;
  logic              mac_en;
  logic              sat_en;
  logic              ovr_d;

  logic [IW-1:0]     cur_in;
  logic [VW-1:0]     cur_vol;
  logic [PW-1:0]     prod;
  logic [SW-1:0]     shifted;
  logic [SW-1:0]     sat_val;

  // Assert asynchronously, release on the clock so no flop leaves reset mid-cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_i = rst_sync[1];

  always_ff @(posedge clk_sys or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_ce) state_nxt = S_MAC;
      S_MAC:   if (idx == LAST_IDX) state_nxt = S_SAT;
      S_SAT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    mac_en  = 1'b0;
    sat_en  = 1'b0;
    ovr_d   = 1'b0;
    busy    = 1'b0;
    case (state)
      S_IDLE: capture = sample_ce;
      S_MAC: begin
        mac_en = 1'b1;
        ovr_d  = sample_ce;
        busy   = 1'b1;
      end
      S_SAT: begin
        sat_en = 1'b1;
        ovr_d  = sample_ce;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_in  = sh_in[idx*IW +: IW];
    cur_vol = sh_vol[idx*VW +: VW];
    prod    = PW'(cur_in) * PW'(cur_vol);
    if (sh_mute[idx]) begin
      prod = '0;
    end
  end

  always_comb begin
    shifted = SW'(acc) << SHIFT;
    sat_val = (shifted > OMAX) ? OMAX : shifted;
    if (sh_master) begin
      sat_val = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_in     <= '0;
      sh_vol    <= '0;
      sh_mute   <= '0;
      sh_master <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= sat_en;
      overrun   <= ovr_d;
      if (capture) begin
        sh_in     <= ch_in;
        sh_vol    <= ch_vol;
        sh_mute   <= ch_mute;
        sh_master <= master_mute;
        acc       <= '0;
        idx       <= '0;
      end
      if (mac_en) begin
        acc <= acc + AW'(prod);
        idx <= idx + 1'b1;
      end
      if (sat_en) begin
        audio_out <= sat_val[OW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pc8001m_audio_mix.sv
// tb/tb_pc8001m_audio_mix.sv - scoreboard bench for pc8001m_audio_mix
module tb_pc8001m_audio_mix;

  localparam int NCH = 4;
  localparam int IW  = 4;
  localparam int VW  = 4;
  localparam int OW  = 16;
  localparam int LAT = NCH + 2;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              sample_ce;
  logic [NCH*IW-1:0] ch_in;
  logic [NCH*VW-1:0] ch_vol;
  logic [NCH-1:0]    ch_mute;
  logic              master_mute;
  logic [OW-1:0]     audio_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  typedef struct {
    logic [OW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   ovr_cycles = 0;
  int   idle_viol = 0;
  bit   idle_chk = 1'b0;

  pc8001m_audio_mix #(
    .NCH(NCH), .IW(IW), .VW(VW), .OW(OW), .SHIFT(8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .sample_ce   (sample_ce),
    .ch_in       (ch_in),
    .ch_vol      (ch_vol),
    .ch_mute     (ch_mute),
    .master_mute (master_mute),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    if (idle_chk && (audio_out != '0 || out_valid || busy || overrun)) idle_viol++;
    if (overrun) ovr_cycles++;
    if (!reset_n) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      check("busy_len", busy_run, NCH + 1);
      busy_run = 0;
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("audio", audio_out, e.val);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [OW-1:0] v);
    exp_t e;
    e.val = v;
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic run_sample(input logic [15:0] ci, input logic [15:0] cv,
                            input logic [3:0] cm, input logic mm, input logic [OW-1:0] v);
    step();
    ch_in = ci; ch_vol = cv; ch_mute = cm; master_mute = mm;
    sample_ce = 1'b1;
    push(v);
    step();
    sample_ce = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    reset_n = 1'b0; sample_ce = 1'b0;
    ch_in = '0; ch_vol = '0; ch_mute = '0; master_mute = 1'b0;
    repeat (3) step();
    check("reset_state", {audio_out, out_valid, busy, overrun}, 0);
    reset_n = 1'b1;
    idle_chk = 1'b1;
    repeat (100) step();
    idle_chk = 1'b0;
    check("idle_quiet", idle_viol, 0);

    run_sample(16'h000F, 16'h000F, 4'b0000, 1'b0, 16'd57600);
    run_sample(16'hFFFF, 16'hFFFF, 4'b0000, 1'b0, 16'd65535);
    run_sample(16'hF000, 16'hFFFF, 4'b0000, 1'b0, 16'd57600);
    run_sample(16'h0000, 16'hFFFF, 4'b0000, 1'b0, 16'd0);
    run_sample(16'h0F80, 16'h0F20, 4'b0100, 1'b0, 16'd4096);
    run_sample(16'h0F80, 16'h0F20, 4'b0100, 1'b1, 16'd0);

    // Back-to-back sample_ce: second request lands in MAC and is dropped.
    step();
    ch_in = 16'h0003; ch_vol = 16'h0002; ch_mute = '0; master_mute = 1'b0;
    sample_ce = 1'b1;
    push(16'd1536);
    step();
    step();
    sample_ce = 1'b0;
    repeat (8) step();
    check("overrun_count", ovr_cycles, 1);

    // Accept in the out_valid cycle; inputs changed during MAC must be ignored.
    step();
    ch_in = 16'h1234; ch_vol = 16'h4321;
    sample_ce = 1'b1;
    push(16'd5120);
    step();
    sample_ce = 1'b0;
    ch_in = 16'hFFFF; ch_vol = 16'hFFFF;
    repeat (5) step();
    check("valid_cycle_seen", out_valid, 1);
    sample_ce = 1'b1;
    push(16'd65535);
    step();
    sample_ce = 1'b0;
    repeat (8) step();
    check("no_overrun_on_valid", ovr_cycles, 1);

    // Reset aborts an in-flight computation.
    step();
    ch_in = 16'h000F; ch_vol = 16'h000F;
    sample_ce = 1'b1;
    step();
    sample_ce = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    step();
    check("abort_audio", audio_out, 0);
    check("abort_busy", busy, 0);
    reset_n = 1'b1;
    repeat (4) step();
    run_sample(16'h000F, 16'h000F, 4'b0000, 1'b0, 16'd57600);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("drain", sb.size(), 0);
    check("overrun_final", ovr_cycles, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
